ocp2axi_cpl: RTL

- Downstream return path of the PCIe-to-OCP bridge. Takes the read-request context from the TLP/OCP translator and collects the byte-wide OCP read response.
- Builds a 3DW PCIe completion TLP (CplD, or Cpl on error) and drives it onto a 64-bit AXI4-Stream master toward the PCIe TX FIFO.
- One completion per request, no reordering.

---
 rtl/ocp2axi_cpl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ocp2axi_cpl.sv
// ocp2axi_cpl: collects a byte-wide OCP read response and emits it as a
// 3DW PCIe completion TLP (CplD, or Cpl on error) on a 64-bit AXI4-Stream master.
module ocp2axi_cpl #(
  parameter logic [15:0] COMPLETER_ID = 16'h0100,
  parameter int unsigned FIFO_WDTH    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [15:0]            req_id,
  input  logic [7:0]             req_tag,
  input  logic [6:0]             req_lower_addr,
  input  logic [9:0]             req_length,
  input  logic [1:0]             sresp,
  input  logic [7:0]             sdata,
  output logic                   mrespaccept,
  output logic                   s_axis_tvalid,
  input  logic                   s_axis_tready,
  output logic [FIFO_WDTH-1:0]   s_axis_tdata,
  output logic [FIFO_WDTH/8-1:0] s_axis_tkeep,
  output logic                   s_axis_tlast
);

  typedef enum logic [2:0] {IDLE, FIRST, HDR0, HDR1, DATA} state_t;

  state_t                 state_q;
  logic                   req_ready_q, mrespaccept_q, tvalid_q, tlast_q;
  logic [FIFO_WDTH-1:0]   tdata_q, beat_q;
  logic [FIFO_WDTH/8-1:0] tkeep_q;
  logic [15:0]            id_q;
  logic [7:0]             tag_q;
  logic [6:0]             la_q;
  logic [9:0]             len_q;
  logic [12:0]            total_q, done_q;
  logic [2:0]             lane_q;
  logic                   err_q;

  logic                   resp_any;
  logic [7:0]             byte_d;
  logic [FIFO_WDTH-1:0]   beat_d;
  logic [12:0]            done_d, total_d;
  logic                   last_d, pend_d;
  logic [FIFO_WDTH/8-1:0] keep_last;
  logic [31:0]            dw2;

  // DW0/DW1 of the completion header; bytes are little-endian across lanes.
  function automatic logic [63:0] build_hdr(input logic e, input logic [9:0] len,
                                            input logic [11:0] total);
    logic [9:0]  l;
    logic [11:0] bc;
    logic [2:0]  st;
    l  = e ? 10'd0 : len;
    bc = e ? 12'd4 : total;
    st = e ? 3'b100 : 3'b000;
    build_hdr = {bc[7:0], st, 1'b0, bc[11:8], COMPLETER_ID[7:0], COMPLETER_ID[15:8],
                 l[7:0], 6'b0, l[9:8], 8'h00, (e ? 8'h0A : 8'h4A)};
  endfunction

  // Byte insertion into the assembly beat and pending/last detection.
  always_comb begin
    resp_any  = (sresp != 2'b00);
    byte_d    = (sresp == 2'b01) ? sdata : 8'hFF;
    beat_d    = beat_q;
    beat_d[{lane_q, 3'b000} +: 8] = byte_d;
    done_d    = done_q + 13'd1;
    last_d    = (done_d == total_q);
    pend_d    = (lane_q == 3'd7) || last_d;
    keep_last = 8'hFF >> (3'd7 - lane_q);
    dw2       = {1'b0, la_q, tag_q, id_q[7:0], id_q[15:8]};
    total_d   = (req_length == 10'd0) ? 13'd4096 : {1'b0, req_length, 2'b00};
  end

  // Completion FSM with registered handshake and stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      mrespaccept_q <= 1'b0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      beat_q        <= '0;
      id_q          <= '0;
      tag_q         <= '0;
      la_q          <= '0;
      len_q         <= '0;
      total_q       <= '0;
      done_q        <= '0;
      lane_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_ready_q && req_valid) begin
            id_q          <= req_id;
            tag_q         <= req_tag;
            la_q          <= req_lower_addr;
            len_q         <= req_length;
            total_q       <= total_d;
            done_q        <= '0;
            lane_q        <= '0;
            err_q         <= 1'b0;
            beat_q        <= '0;
            req_ready_q   <= 1'b0;
            mrespaccept_q <= 1'b1;
            state_q       <= FIRST;
          end else begin
            req_ready_q   <= 1'b1;
          end
        end
        FIRST: begin
          if (resp_any) begin
            mrespaccept_q <= 1'b0;
            tvalid_q      <= 1'b1;
            tkeep_q       <= '1;
            tlast_q       <= 1'b0;
            if (sresp == 2'b01) begin
              beat_q  <= {24'h0, sdata, dw2};
              done_q  <= 13'd1;
              tdata_q <= build_hdr(1'b0, len_q, total_q[11:0]);
            end else begin
              err_q   <= 1'b1;
              tdata_q <= build_hdr(1'b1, len_q, total_q[11:0]);
            end
            state_q <= HDR0;
          end
        end
        HDR0: begin
          if (s_axis_tready) begin
            if (err_q) begin
              tdata_q <= {32'h0, dw2};
              tkeep_q <= 8'h0F;
              tlast_q <= 1'b1;
              state_q <= HDR1;
            end else begin
              tvalid_q      <= 1'b0;
              tkeep_q       <= '0;
              lane_q        <= 3'd5;
              mrespaccept_q <= 1'b1;
              state_q       <= DATA;
            end
          end
        end
        HDR1: begin
          if (s_axis_tready) begin
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tkeep_q     <= '0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        DATA: begin
          if (tvalid_q) begin
            if (s_axis_tready) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tkeep_q  <= '0;
              lane_q   <= '0;
              beat_q   <= '0;
              if (tlast_q) begin
                req_ready_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                mrespaccept_q <= 1'b1;
              end
            end
          end else if (resp_any) begin
            beat_q <= beat_d;
            done_q <= done_d;
            lane_q <= lane_q + 3'd1;
            if (pend_d) begin
              tvalid_q      <= 1'b1;
              mrespaccept_q <= 1'b0;
              tdata_q       <= beat_d;
              tlast_q       <= last_d;
              tkeep_q       <= last_d ? keep_last : '1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign mrespaccept   = mrespaccept_q;
  assign s_axis_tvalid = tvalid_q;
  assign s_axis_tdata  = tdata_q;
  assign s_axis_tkeep  = tkeep_q;
  assign s_axis_tlast  = tlast_q;

endmodule
